// File: rtl/wb_hub_pkg.sv
// Shared definitions for the Wishbone peripheral hub: CSR map, FSM states, request payload.
package wb_hub_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 4;

    localparam logic [7:0] CSR_STATUS   = 8'h00;
    localparam logic [7:0] CSR_CONTROL  = 8'h04;
    localparam logic [7:0] CSR_VERSION  = 8'h08;
    localparam logic [7:0] CSR_IRQ_EN   = 8'h0C;
    localparam logic [7:0] CSR_IRQ_PEND = 8'h10;
    localparam logic [7:0] CSR_ERR      = 8'h14;

    localparam logic [3:0]    CSR_REGION   = 4'hF;
    localparam logic [DW-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_RESP
    } hub_state_e;

    typedef struct packed {
        logic          we;
        logic [SW-1:0] sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } wb_req_t;

    // Expand byte selects into a per-bit write mask.
    function automatic logic [DW-1:0] sel_to_mask(input logic [SW-1:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_hub_irq_ctrl.sv
// Interrupt aggregation: rising-edge latch into IRQ_PEND, IRQ_EN mask, registered irq_o.
module wb_hub_irq_ctrl #(
    parameter int unsigned NSLV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSLV-1:0] irq_i,
    input  logic            en_we,
    input  logic            pend_we,
    input  logic [NSLV-1:0] wdata,
    input  logic [NSLV-1:0] wmask,
    output logic [NSLV-1:0] irq_en,
    output logic [NSLV-1:0] irq_pend,
    output logic            irq_o
);

    logic [NSLV-1:0] irq_q;
    logic [NSLV-1:0] rise;
    logic [NSLV-1:0] w1c;

    assign rise = irq_i & ~irq_q;
    assign w1c  = pend_we ? (wdata & wmask) : '0;

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q    <= '0;
            irq_en   <= '0;
            irq_pend <= '0;
            irq_o    <= 1'b0;
        end else begin
            irq_q    <= irq_i;
            irq_pend <= (irq_pend & ~w1c) | rise;
            irq_o    <= |(irq_pend & irq_en);
            if (en_we) begin
                irq_en <= (irq_en & ~wmask) | (wdata & wmask);
            end
        end
    end

endmodule

// File: rtl/wb_periph_hub.sv
// Wishbone hub: decodes one master port onto NSLV peripherals plus a local CSR bank,
// with per-transaction timeout and aggregated interrupt.
module wb_periph_hub
    import wb_hub_pkg::*;
#(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [31:0] VERSION = 32'h0200_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_cyc_i,
    input  logic               m_stb_i,
    input  logic               m_we_i,
    input  logic [3:0]         m_sel_i,
    input  logic [31:0]        m_adr_i,
    input  logic [31:0]        m_dat_i,
    output logic               m_ack_o,
    output logic [31:0]        m_dat_o,
    output logic [NSLV-1:0]    s_cyc_o,
    output logic [NSLV-1:0]    s_stb_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    input  logic [NSLV-1:0]    s_ack_i,
    input  logic [NSLV*32-1:0] s_dat_i,
    input  logic [NSLV-1:0]    irq_i,
    output logic               irq_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    hub_state_e       state_q, state_d;
    wb_req_t          m_req, req_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NSLV-1:0]  control_q;
    logic [15:0]      tmo_cnt_q;
    logic             dec_err_q;
    logic [NSLV-1:0]  irq_en, irq_pend;

    logic [3:0]      region;
    logic [NSLV-1:0] hit;
    logic            req_c, is_csr, slv_ack, tmo_hit;
    logic [31:0]     slv_rdata, csr_rdata;
    logic [NSLV-1:0] wmask;
    logic            start_fwd, csr_go, dec_err, fwd_done, fwd_tmo, fwd_abort;
    logic            csr_wr, err_clr;
    logic [15:0]     tmo_base;

    assign m_req   = '{we: m_we_i, sel: m_sel_i, adr: m_adr_i, dat: m_dat_i};
    assign region  = m_adr_i[15:12];
    assign req_c   = m_cyc_i & m_stb_i;
    assign is_csr  = (region == CSR_REGION);
    assign slv_ack = |(s_ack_i & s_cyc_o);
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign wmask   = NSLV'(sel_to_mask(m_sel_i));
    assign csr_wr  = csr_go & m_we_i;
    assign err_clr = csr_wr && (m_adr_i[7:0] == CSR_ERR);

    // Region decode and read-data mux of the selected slave.
    always_comb begin
        hit       = '0;
        slv_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            hit[i] = (region == 4'(i)) && control_q[i];
            if (s_cyc_o[i]) begin
                slv_rdata = slv_rdata | s_dat_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (m_adr_i[7:0])
            CSR_STATUS:   csr_rdata = 32'(irq_i);
            CSR_CONTROL:  csr_rdata = 32'(control_q);
            CSR_VERSION:  csr_rdata = VERSION;
            CSR_IRQ_EN:   csr_rdata = 32'(irq_en);
            CSR_IRQ_PEND: csr_rdata = 32'(irq_pend);
            CSR_ERR:      csr_rdata = {15'd0, dec_err_q, tmo_cnt_q};
            default:      csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks a same-cycle ack; ack outranks a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        start_fwd = 1'b0;
        csr_go    = 1'b0;
        dec_err   = 1'b0;
        fwd_done  = 1'b0;
        fwd_tmo   = 1'b0;
        fwd_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (is_csr) begin
                        csr_go  = 1'b1;
                        state_d = ST_RESP;
                    end else if (|hit) begin
                        start_fwd = 1'b1;
                        state_d   = ST_FWD;
                    end else begin
                        dec_err = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_FWD: begin
                if (!m_cyc_i) begin
                    fwd_abort = 1'b1;
                    state_d   = ST_IDLE;
                end else if (slv_ack) begin
                    fwd_done = 1'b1;
                    state_d  = ST_RESP;
                end else if (tmo_hit) begin
                    fwd_tmo = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            s_cyc_o <= '0;
            cnt_q   <= '0;
            m_ack_o <= 1'b0;
            m_dat_o <= '0;
        end else begin
            m_ack_o <= (state_d == ST_RESP);
            if ((state_q == ST_IDLE) && req_c) begin
                req_q <= m_req;
            end
            if (start_fwd) begin
                s_cyc_o <= hit;
                cnt_q   <= '0;
            end else begin
                if (fwd_done || fwd_tmo || fwd_abort) begin
                    s_cyc_o <= '0;
                end
                if (state_q == ST_FWD) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (csr_go) begin
                m_dat_o <= m_we_i ? '0 : csr_rdata;
            end else if (dec_err) begin
                m_dat_o <= '0;
            end else if (fwd_done) begin
                m_dat_o <= req_q.we ? '0 : slv_rdata;
            end else if (fwd_tmo) begin
                m_dat_o <= TIMEOUT_DATA;
            end
        end
    end

    assign tmo_base = err_clr ? 16'd0 : tmo_cnt_q;

    // CONTROL and ERR registers; a clearing write loses to a new error.
    always_ff @(posedge clk) begin
        if (rst) begin
            control_q <= '1;
            tmo_cnt_q <= '0;
            dec_err_q <= 1'b0;
        end else begin
            if (csr_wr && (m_adr_i[7:0] == CSR_CONTROL)) begin
                control_q <= (control_q & ~wmask) | (m_dat_i[NSLV-1:0] & wmask);
            end
            dec_err_q <= dec_err | (dec_err_q & ~err_clr);
            if (fwd_tmo && (tmo_base != 16'hFFFF)) begin
                tmo_cnt_q <= tmo_base + 16'd1;
            end else begin
                tmo_cnt_q <= tmo_base;
            end
        end
    end

    assign s_stb_o = s_cyc_o;
    assign s_we_o  = req_q.we;
    assign s_sel_o = req_q.sel;
    assign s_adr_o = req_q.adr;
    assign s_dat_o = req_q.dat;

    wb_hub_irq_ctrl #(
        .NSLV(NSLV)
    ) u_irq (
        .clk     (clk),
        .rst     (rst),
        .irq_i   (irq_i),
        .en_we   (csr_wr && (m_adr_i[7:0] == CSR_IRQ_EN)),
        .pend_we (csr_wr && (m_adr_i[7:0] == CSR_IRQ_PEND)),
        .wdata   (m_dat_i[NSLV-1:0]),
        .wmask   (wmask),
        .irq_en  (irq_en),
        .irq_pend(irq_pend),
        .irq_o   (irq_o)
    );

endmodule
